// File: rtl/sdram_writeback_pkg.sv
// Shared types and constants for the SDRAM write-back engine (package sdram_wb_pkg).
// Orientation helpers treat the reserved modes 4-7 as normal.
package sdram_wb_pkg;

    localparam int ADDR_W = 26;
    localparam int DIM_W  = 13;

    localparam logic [2:0] MODE_NORMAL = 3'd0;
    localparam logic [2:0] MODE_HFLIP  = 3'd1;
    localparam logic [2:0] MODE_VFLIP  = 3'd2;
    localparam logic [2:0] MODE_ROT180 = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > MODE_ROT180) ? MODE_NORMAL : m;
    endfunction

    function automatic logic is_hflip(input logic [2:0] m);
        return (m == MODE_HFLIP) || (m == MODE_ROT180);
    endfunction

    function automatic logic is_vflip(input logic [2:0] m);
        return (m == MODE_VFLIP) || (m == MODE_ROT180);
    endfunction

endpackage

// File: rtl/sdram_writeback_if.sv
// Memory-side bus of the write-back engine: SRAM read port plus SDRAM write port.
// The engine uses the master modport, the memory model/controller the slave modport.
interface sdram_writeback_if #(
    parameter int DATA_W = 32
);
    import sdram_wb_pkg::*;

    logic              sram_read;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_rdata;
    logic              sdram_write;
    logic [ADDR_W-1:0] sdram_address;
    logic [DATA_W-1:0] sdram_wdata;
    logic              sdram_ack;

    modport master (
        output sram_read, sram_address,
        input  sram_rdata,
        output sdram_write, sdram_address, sdram_wdata,
        input  sdram_ack
    );

    modport slave (
        input  sram_read, sram_address,
        output sram_rdata,
        input  sdram_write, sdram_address, sdram_wdata,
        output sdram_ack
    );

endinterface

// File: rtl/sdram_writeback_raster_counter.sv
// Raster position tracker: column x, row y and linear pixel index, with last-pixel detection.
// On the last pixel an advance wraps everything back to zero.
module raster_counter
    import sdram_wb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [DIM_W-1:0]  x,
    output logic [ADDR_W-1:0] lin,
    output logic              row_end,
    output logic              last
);
    logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] lin_q, lin_d;

    assign x       = x_q;
    assign lin     = lin_q;
    assign row_end = (x_q == width - DIM_W'(1));
    assign last    = row_end && (y_q == height - DIM_W'(1));

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        lin_d = lin_q;
        if (clear) begin
            x_d   = '0;
            y_d   = '0;
            lin_d = '0;
        end else if (advance) begin
            x_d   = row_end ? '0 : x_q + DIM_W'(1);
            y_d   = last ? '0 : (row_end ? y_q + DIM_W'(1) : y_q);
            lin_d = last ? '0 : lin_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q   <= '0;
            y_q   <= '0;
            lin_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            lin_q <= lin_d;
        end
    end

endmodule

// File: rtl/sdram_writeback.sv
// Drains a W x H image from SRAM in raster order and writes it to SDRAM with orientation remap.
// Optional write-ack timeout is enabled by defining SDRAM_WB_TIMEOUT_EN.
module sdram_writeback
    import sdram_wb_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] SRAM_BASE = '0
`ifdef SDRAM_WB_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
    input  logic [ADDR_W-1:0]    dest_base,
    input  logic [2:0]           mode,
    sdram_writeback_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    state_t            state_q, state_d;
    logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              cnt_clear, cnt_adv, row_end, last;
    logic [DIM_W-1:0]  x;
    logic [ADDR_W-1:0] lin, col_off, last_row_off;
    logic [2:0]        new_mode;

`ifdef SDRAM_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             error_q, error_d;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    raster_counter u_raster (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .width   (w_q),
        .height  (h_q),
        .x       (x),
        .lin     (lin),
        .row_end (row_end),
        .last    (last)
    );

    assign new_mode     = norm_mode(mode);
    // The single multiply: offset of the bottom row, used only when a transfer starts.
    assign last_row_off = ADDR_W'(height - DIM_W'(1)) * ADDR_W'(width);
    assign col_off      = is_hflip(mode_q) ? ADDR_W'(w_q - DIM_W'(1) - x) : ADDR_W'(x);

    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign bus.sram_read     = (state_q == READ);
    assign bus.sram_address  = bus.sram_read ? SRAM_BASE + lin : '0;
    assign bus.sdram_write   = (state_q == WRITE);
    assign bus.sdram_address = bus.sdram_write ? row_base_q + col_off : '0;
    assign bus.sdram_wdata   = bus.sdram_write ? data_q : '0;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        mode_d     = mode_q;
        row_base_d = row_base_q;
        data_d     = data_q;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
`ifdef SDRAM_WB_TIMEOUT_EN
        tmo_d      = '0;
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d        = width;
                    h_d        = height;
                    mode_d     = new_mode;
                    row_base_d = is_vflip(new_mode) ? dest_base + last_row_off : dest_base;
                    cnt_clear  = 1'b1;
`ifdef SDRAM_WB_TIMEOUT_EN
                    error_d    = 1'b0;
`endif
                    state_d    = (width == '0 || height == '0) ? DONE : READ;
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                data_d  = bus.sram_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                if (bus.sdram_ack) begin
                    cnt_adv = 1'b1;
                    if (row_end && !last)
                        row_base_d = is_vflip(mode_q) ? row_base_q - ADDR_W'(w_q)
                                                      : row_base_q + ADDR_W'(w_q);
                    state_d = last ? DONE : READ;
                end
`ifdef SDRAM_WB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            mode_q     <= MODE_NORMAL;
            row_base_q <= '0;
            data_q     <= '0;
`ifdef SDRAM_WB_TIMEOUT_EN
            tmo_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            mode_q     <= mode_d;
            row_base_q <= row_base_d;
            data_q     <= data_d;
`ifdef SDRAM_WB_TIMEOUT_EN
            tmo_q      <= tmo_d;
            error_q    <= error_d;
`endif
        end
    end

endmodule
